// File: rtl/mem_phase_if.sv
// Bus-side phase decoder for the multicycle core's one-hot phase ring.
// Issues IF fetches and MEM loads/stores on one valid/ready port, stalls the ring meanwhile.
//
// Ports:
//   clk, rstn                         clock, async active-low reset
//   state[NSTATE]                     one-hot phase (0=IF,1=ID,2=EX,3=MEM,4=WB)
//   hold                              flush, asserted with the ring forced to IF
//   mem_rd, mem_wr                    load/store flags for the MEM phase
//   pc, ls_addr, ls_wdata             fetch address, load/store address, store data
//   bus_req/we/addr/wdata             registered request side of the memory port
//   bus_ready, bus_rdata              responder handshake and read data
//   stall                             ring must not rotate while high
//   inst_o, ld_data                   last fetched instruction, last load data
//   err_o                             one-cycle pulse on timeout abort
//   stall_cnt                         saturating count of stall cycles
module mem_phase_if #(
    parameter int              NSTATE  = 5,
    parameter int              AW      = 32,
    parameter int              DW      = 32,
    parameter int              TIMEOUT = 255,
    parameter int              TW      = 8,
    parameter logic [DW-1:0]   NOP     = 'h13
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NSTATE-1:0] state,
    input  logic              hold,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [AW-1:0]     pc,
    input  logic [AW-1:0]     ls_addr,
    input  logic [DW-1:0]     ls_wdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [AW-1:0]     bus_addr,
    output logic [DW-1:0]     bus_wdata,
    input  logic              bus_ready,
    input  logic [DW-1:0]     bus_rdata,
    output logic              stall,
    output logic [DW-1:0]     inst_o,
    output logic [DW-1:0]     ld_data,
    output logic              err_o,
    output logic [31:0]       stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic              served_q, served_d;
    logic [NSTATE-1:0] prev_state_q, prev_state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [AW-1:0]     bus_addr_q, bus_addr_d;
    logic [DW-1:0]     bus_wdata_q, bus_wdata_d;
    logic [DW-1:0]     inst_q, inst_d;
    logic [DW-1:0]     ld_q, ld_d;
    logic              err_q, err_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              is_if_q, is_if_d;
    logic              is_rd_q, is_rd_d;
    logic              flush_q, flush_d;

    logic          phase_req;
    logic          set_served;
    logic          discard;
    logic [TW-1:0] tmo_inc;

    assign phase_req = state[0] | (state[3] & (mem_rd | mem_wr));
    assign stall     = phase_req & ~served_q & ~hold;
    assign tmo_inc   = tmo_q + TW'(1);

    always_comb begin
        fsm_d        = fsm_q;
        prev_state_d = state;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        inst_d       = inst_q;
        ld_d         = ld_q;
        err_d        = 1'b0;
        tmo_d        = tmo_q;
        is_if_d      = is_if_q;
        is_rd_d      = is_rd_q;
        flush_d      = flush_q;
        set_served   = 1'b0;
        // A flush seen at any point of the handshake discards the result.
        discard      = flush_q | hold;

        unique case (fsm_q)
            IDLE: begin
                if (stall) begin
                    fsm_d       = REQ;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = state[0] ? pc : ls_addr;
                    bus_we_d    = state[3] & mem_wr;
                    bus_wdata_d = ls_wdata;
                    tmo_d       = '0;
                    is_if_d     = state[0];
                    is_rd_d     = ~state[0] & state[3] & mem_rd & ~mem_wr;
                    flush_d     = 1'b0;
                end
            end
            REQ: begin
                flush_d = discard;
                if (bus_ready) begin
                    fsm_d     = IDLE;
                    bus_req_d = 1'b0;
                    if (!discard) begin
                        set_served = 1'b1;
                        if (is_if_q) begin
                            inst_d = bus_rdata;
                        end else if (is_rd_q) begin
                            ld_d = bus_rdata;
                        end
                    end
                end else if (tmo_inc == TW'(TIMEOUT)) begin
                    fsm_d     = IDLE;
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (!discard) begin
                        set_served = 1'b1;
                        if (is_if_q) begin
                            inst_d = NOP;
                        end else if (is_rd_q) begin
                            ld_d = '0;
                        end
                    end
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            default: fsm_d = IDLE;
        endcase

        // A phase change always clears served, even over a same-cycle completion.
        if (state != prev_state_q) begin
            served_d = 1'b0;
        end else if (set_served) begin
            served_d = 1'b1;
        end else begin
            served_d = served_q;
        end

        if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_q        <= IDLE;
            served_q     <= 1'b0;
            prev_state_q <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            inst_q       <= '0;
            ld_q         <= '0;
            err_q        <= 1'b0;
            stall_cnt_q  <= '0;
            tmo_q        <= '0;
            is_if_q      <= 1'b0;
            is_rd_q      <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            served_q     <= served_d;
            prev_state_q <= prev_state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_q       <= inst_d;
            ld_q         <= ld_d;
            err_q        <= err_d;
            stall_cnt_q  <= stall_cnt_d;
            tmo_q        <= tmo_d;
            is_if_q      <= is_if_d;
            is_rd_q      <= is_rd_d;
            flush_q      <= flush_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign inst_o    = inst_q;
    assign ld_data   = ld_q;
    assign err_o     = err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_phase_if.sv
// Directed bench for mem_phase_if.
// Bus transactions are scoreboarded; registered results are checked per cycle.
module tb_mem_phase_if;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } tx_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic [4:0]    state;
    logic          hold;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] pc;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ready;
    logic [DW-1:0] bus_rdata;
    logic          stall;
    logic [DW-1:0] inst_o;
    logic [DW-1:0] ld_data;
    logic          err_o;
    logic [31:0]   stall_cnt;

    int  ncmp = 0;
    int  nerr = 0;
    tx_t txq[$];
    tx_t tx;

    always #5 clk = ~clk;

    mem_phase_if #(
        .NSTATE (5),
        .AW     (AW),
        .DW     (DW),
        .TIMEOUT(4),
        .TW     (8),
        .NOP    (32'h0000_0013)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .state    (state),
        .hold     (hold),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .pc       (pc),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ready(bus_ready),
        .bus_rdata(bus_rdata),
        .stall    (stall),
        .inst_o   (inst_o),
        .ld_data  (ld_data),
        .err_o    (err_o),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic phase(input int p);
        state = 5'b00001 << p;
    endtask

    task automatic push(input logic [31:0] a, input logic we,
                        input logic [31:0] wd);
        tx_t t;
        t.addr  = a;
        t.we    = we;
        t.wdata = wd;
        txq.push_back(t);
    endtask

    // Bus monitor: every request cycle must match the oldest expected
    // transaction; the handshake retires it.
    always @(negedge clk) begin
        if (rstn && bus_req) begin
            ncmp++;
            assert (txq.size() != 0) else begin
                nerr++;
                $error("FAIL bus_unexpected: observed req addr %h expected none",
                       bus_addr);
            end
            if (txq.size() != 0) begin
                tx = txq[0];
                chk("bus_addr", bus_addr, tx.addr);
                chk("bus_we", 32'(bus_we), 32'(tx.we));
                if (tx.we) begin
                    chk("bus_wdata", bus_wdata, tx.wdata);
                end
                if (bus_ready) begin
                    void'(txq.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn      = 1'b0;
        state     = '0;
        hold      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        pc        = '0;
        ls_addr   = '0;
        ls_wdata  = '0;
        bus_ready = 1'b0;
        bus_rdata = '0;
        cyc();
        cyc();
        chk("rst_req", 32'(bus_req), 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_ld", ld_data, 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_scnt", stall_cnt, 0);
        rstn = 1'b1;

        // Zero-wait fetch
        cyc();
        phase(0);
        pc        = 32'h100;
        bus_ready = 1'b1;
        bus_rdata = 32'h0050_0093;
        push(32'h100, 1'b0, 0);
        settle();
        chk("t1_stall_c0", 32'(stall), 1);
        chk("t1_req_c0", 32'(bus_req), 0);
        cyc();
        settle();
        chk("t1_req_c1", 32'(bus_req), 1);
        chk("t1_stall_c1", 32'(stall), 1);
        cyc();
        settle();
        chk("t1_inst", inst_o, 32'h0050_0093);
        chk("t1_stall_c2", 32'(stall), 0);
        chk("t1_req_c2", 32'(bus_req), 0);
        chk("t1_scnt", stall_cnt, 2);
        cyc();
        phase(1);
        bus_ready = 1'b0;
        cyc();
        phase(2);
        settle();
        chk("ex_stall", 32'(stall), 0);
        chk("ex_req", 32'(bus_req), 0);

        // Load with three wait states
        cyc();
        phase(3);
        mem_rd  = 1'b1;
        ls_addr = 32'h2004;
        push(32'h2004, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            settle();
            chk("t2_req_wait", 32'(bus_req), 1);
        end
        cyc();
        bus_ready = 1'b1;
        bus_rdata = 32'hCAFE_0001;
        settle();
        chk("t2_req_last", 32'(bus_req), 1);
        cyc();
        bus_ready = 1'b0;
        settle();
        chk("t2_ld", ld_data, 32'hCAFE_0001);
        chk("t2_stall", 32'(stall), 0);
        chk("t2_scnt", stall_cnt, 7);
        cyc();
        phase(4);
        mem_rd = 1'b0;
        settle();
        chk("t2_inst_kept", inst_o, 32'h0050_0093);

        // Back-to-back fetch after WB, then a store
        cyc();
        phase(0);
        pc        = 32'h104;
        bus_ready = 1'b1;
        bus_rdata = 32'h00A0_0113;
        push(32'h104, 1'b0, 0);
        cyc();
        settle();
        chk("t3_req_b2b", 32'(bus_req), 1);
        cyc();
        settle();
        chk("t3_inst", inst_o, 32'h00A0_0113);
        cyc();
        phase(1);
        cyc();
        phase(2);
        cyc();
        phase(3);
        mem_wr   = 1'b1;
        ls_addr  = 32'h3000;
        ls_wdata = 32'hDEAD_BEEF;
        push(32'h3000, 1'b1, 32'hDEAD_BEEF);
        cyc();
        settle();
        chk("t3_we", 32'(bus_we), 1);
        chk("t3_wdata", bus_wdata, 32'hDEAD_BEEF);
        cyc();
        settle();
        chk("t3_ld_kept", ld_data, 32'hCAFE_0001);
        chk("t3_stall", 32'(stall), 0);
        chk("t3_scnt", stall_cnt, 11);
        cyc();
        phase(4);
        mem_wr    = 1'b0;
        bus_ready = 1'b0;

        // Fetch timeout
        cyc();
        phase(0);
        pc = 32'h108;
        push(32'h108, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            settle();
            chk("t4_req_held", 32'(bus_req), 1);
            chk("t4_err_low", 32'(err_o), 0);
        end
        cyc();
        settle();
        chk("t4_req_drop", 32'(bus_req), 0);
        chk("t4_err", 32'(err_o), 1);
        chk("t4_inst_nop", inst_o, 32'h0000_0013);
        chk("t4_stall", 32'(stall), 0);
        void'(txq.pop_front());
        cyc();
        settle();
        chk("t4_err_pulse", 32'(err_o), 0);
        chk("t4_scnt", stall_cnt, 16);
        cyc();
        phase(1);
        cyc();
        phase(2);
        cyc();
        phase(3);
        settle();
        chk("mem_nols_stall", 32'(stall), 0);
        cyc();
        settle();
        chk("mem_nols_req", 32'(bus_req), 0);
        cyc();
        phase(4);

        // Flush during a pending fetch
        cyc();
        phase(0);
        pc = 32'h200;
        push(32'h200, 1'b0, 0);
        cyc();
        hold = 1'b1;
        settle();
        chk("t5_req_c1", 32'(bus_req), 1);
        chk("t5_stall_hold", 32'(stall), 0);
        cyc();
        settle();
        chk("t5_req_c2", 32'(bus_req), 1);
        cyc();
        hold      = 1'b0;
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_0BAD;
        pc        = 32'h300;
        push(32'h300, 1'b0, 0);
        settle();
        chk("t5_stall_c3", 32'(stall), 1);
        cyc();
        bus_rdata = 32'h0010_8093;
        settle();
        chk("t5_inst_kept", inst_o, 32'h0000_0013);
        chk("t5_req_c4", 32'(bus_req), 0);
        chk("t5_stall_c4", 32'(stall), 1);
        cyc();
        settle();
        chk("t5_req_fresh", 32'(bus_req), 1);
        cyc();
        settle();
        chk("t5_inst_new", inst_o, 32'h0010_8093);
        chk("t5_stall_c6", 32'(stall), 0);
        chk("t5_scnt", stall_cnt, 20);
        cyc();
        phase(1);
        bus_ready = 1'b0;
        cyc();
        phase(2);

        // Reset during REQ
        cyc();
        phase(3);
        mem_rd  = 1'b1;
        ls_addr = 32'h4000;
        push(32'h4000, 1'b0, 0);
        cyc();
        settle();
        chk("t6_req_pre", 32'(bus_req), 1);
        rstn = 1'b0;
        settle();
        void'(txq.pop_front());
        chk("t6_req", 32'(bus_req), 0);
        chk("t6_addr", bus_addr, 0);
        chk("t6_inst", inst_o, 0);
        chk("t6_ld", ld_data, 0);
        chk("t6_scnt", stall_cnt, 0);
        chk("t6_err", 32'(err_o), 0);
        cyc();
        state  = '0;
        mem_rd = 1'b0;
        rstn   = 1'b1;
        cyc();
        settle();
        chk("sb_empty", 32'(txq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
